// File: rtl/ps2_note_keys.sv
// PS/2 keyboard front end: conditions PS2_CLK/PS2_DAT, frames bytes and tracks 12 held notes.
// Optional PS2_NOTE_PANIC_EN: a make of Esc (0x76) clears every held note.
module ps2_note_keys #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [11:0] keys_held,
    output logic [7:0]  scan_code,
    output logic        code_valid,
    output logic        frame_err
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FiltLast = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RxIdle, RxData, RxParity, RxStop} rx_state_e;
    typedef enum logic [1:0] {DecBase, DecBrk, DecExt, DecExtBrk} dec_state_e;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          clk_s, dat_s, fall;

    rx_state_e     rx_state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          byte_good;

    dec_state_e    dec_state_q;
    logic [11:0]   key_mask;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = filt_prev_q & ~filt_q;

    // Stop bit high and odd parity over data plus parity bit.
    assign byte_good = fall && (rx_state_q == RxStop) && dat_s && (^{shift_q, parity_q});

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q  <= {dat_sync_q[0], PS2_DAT};
            filt_prev_q <= filt_q;
            if (clk_s == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FiltLast) begin
                filt_q     <= clk_s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            scan_code  <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_state_q == RxIdle) begin
                tmo_q <= '0;
                if (fall && !dat_s) begin
                    rx_state_q <= RxData;
                    bit_cnt_q  <= '0;
                end
            end else if (fall) begin
                tmo_q <= '0;
                case (rx_state_q)
                    RxData: begin
                        shift_q   <= {dat_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RxParity;
                    end
                    RxParity: begin
                        parity_q   <= dat_s;
                        rx_state_q <= RxStop;
                    end
                    default: begin
                        if (byte_good) begin
                            scan_code  <= shift_q;
                            code_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rx_state_q <= RxIdle;
                    end
                endcase
            end else if (tmo_q == TmoLast) begin
                frame_err  <= 1'b1;
                rx_state_q <= RxIdle;
                tmo_q      <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        key_mask = 12'h000;
        case (shift_q)
            8'h1C: key_mask = 12'h800;
            8'h1D: key_mask = 12'h400;
            8'h1B: key_mask = 12'h200;
            8'h24: key_mask = 12'h100;
            8'h23: key_mask = 12'h080;
            8'h2B: key_mask = 12'h040;
            8'h2C: key_mask = 12'h020;
            8'h34: key_mask = 12'h010;
            8'h35: key_mask = 12'h008;
            8'h33: key_mask = 12'h004;
            8'h3C: key_mask = 12'h002;
            8'h3B: key_mask = 12'h001;
            default: key_mask = 12'h000;
        endcase
    end

    // Decoder consumes the byte on the same edge that publishes scan_code.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            dec_state_q <= DecBase;
            keys_held   <= '0;
        end else if (byte_good) begin
            case (dec_state_q)
                DecBase: begin
                    if (shift_q == 8'hF0) begin
                        dec_state_q <= DecBrk;
                    end else if (shift_q == 8'hE0) begin
                        dec_state_q <= DecExt;
`ifdef PS2_NOTE_PANIC_EN
                    end else if (shift_q == 8'h76) begin
                        keys_held <= '0;
`endif
                    end else begin
                        keys_held <= keys_held | key_mask;
                    end
                end
                DecBrk: begin
                    keys_held   <= keys_held & ~key_mask;
                    dec_state_q <= DecBase;
                end
                DecExt:    dec_state_q <= (shift_q == 8'hF0) ? DecExtBrk : DecBase;
                default:   dec_state_q <= DecBase;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_note_keys.sv
// Scoreboard bench for ps2_note_keys: directed PS/2 frames, monitor checks each output pulse.
module tb_ps2_note_keys;
    localparam int Half = 60;
`ifdef PS2_NOTE_PANIC_EN
    localparam logic [11:0] PanicKeys = 12'h000;
`else
    localparam logic [11:0] PanicKeys = 12'h802;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [11:0] keys_held;
    logic [7:0]  scan_code;
    logic        code_valid;
    logic        frame_err;

    typedef struct {
        logic [7:0]  code;
        logic [11:0] keys;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] err_q[$];
    exp_t        mon_e;
    logic [11:0] mon_k;
    int          checks = 0;
    int          failures = 0;

    ps2_note_keys #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(2000)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .PS2_CLK   (ps2_clk),
        .PS2_DAT   (ps2_dat),
        .keys_held (keys_held),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (Half) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (Half) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] code, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ flip);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (2 * Half) @(posedge clk);
    endtask

    task automatic send(input logic [7:0] code, input logic [11:0] keys);
        exp_t e;
        e.code = code;
        e.keys = keys;
        exp_q.push_back(e);
        send_raw(code, 1'b0);
    endtask

    task automatic send_bad(input logic [7:0] code, input logic [11:0] keys);
        err_q.push_back(keys);
        send_raw(code, 1'b1);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && code_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_code_valid: got scan_code %h, required no pulse", scan_code);
            end else begin
                mon_e = exp_q.pop_front();
                check("scan_code", 16'(scan_code), 16'(mon_e.code));
                check("keys_held", 16'(keys_held), 16'(mon_e.keys));
            end
        end
        if (!reset && frame_err) begin
            if (err_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_err: got pulse, required none");
            end else begin
                mon_k = err_q.pop_front();
                check("err_keys_held", 16'(keys_held), 16'(mon_k));
            end
        end
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("reset_keys_held", 16'(keys_held), 16'h000);
        check("reset_scan_code", 16'(scan_code), 16'h00);
        check("reset_code_valid", 16'(code_valid), 16'h0);
        check("reset_frame_err", 16'(frame_err), 16'h0);
        reset = 1'b0;
        repeat (200) @(posedge clk);
        #1 check("idle_keys_held", 16'(keys_held), 16'h000);

        send(8'h1C, 12'h800);
        send(8'hF0, 12'h800);
        send(8'h1C, 12'h000);

        send(8'h23, 12'h080);
        send(8'h3B, 12'h081);
        send(8'h23, 12'h081);
        send(8'hF0, 12'h081);
        send(8'h23, 12'h001);

        send_bad(8'h1D, 12'h001);
        // Stall after four data bits so the receiver times out.
        err_q.push_back(12'h001);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (3000) @(posedge clk);
        send(8'h1D, 12'h401);

        send(8'hE0, 12'h401);
        send(8'h1C, 12'h401);
        send(8'hE0, 12'h401);
        send(8'hF0, 12'h401);
        send(8'h1C, 12'h401);

        // Short clock glitch with data low: would look like a start bit if accepted.
        ps2_dat = 1'b0;
        repeat (Half) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (Half) @(posedge clk);
        ps2_dat = 1'b1;
        repeat (3000) @(posedge clk);
        #1 check("glitch_keys_held", 16'(keys_held), 16'h401);

        send(8'hF0, 12'h401);
        send(8'h1D, 12'h001);
        send(8'hF0, 12'h001);
        send(8'h3B, 12'h000);
        send(8'h1C, 12'h800);
        send(8'h3C, 12'h802);
        send(8'h76, PanicKeys);
        send(8'hF0, PanicKeys);
        send(8'h76, PanicKeys);
        send(8'hF0, PanicKeys);
        send(8'h34, PanicKeys);

        // Reset in the middle of a frame drops the partial byte and all held notes.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_keys_held", 16'(keys_held), 16'h000);
        check("midreset_scan_code", 16'(scan_code), 16'h00);
        reset = 1'b0;
        repeat (200) @(posedge clk);
        send(8'h1C, 12'h800);

        repeat (500) @(posedge clk);
        check("code_queue_drained", 16'(exp_q.size()), 16'h0);
        check("err_queue_drained", 16'(err_q.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
